// File: rtl/top_with_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_with_mem_pkg
// Description : Shared widths and the lane rotation helper for top_with_mem.
// Revision    : 1.0 - initial release
// ============================================================================
package top_with_mem_pkg;

    localparam int Y_W     = 256;
    localparam int Y_DEPTH = 256;
    localparam int LANE_W  = 16;
    localparam int I_W     = 240;
    localparam int I_DEPTH = 256;
    localparam int PIX_W   = 48;

    // Rotate right by whole 16-bit lanes; lanes leaving the bottom re-enter at the top.
    function automatic logic [Y_W-1:0] lane_rotate(input logic [Y_W-1:0] d,
                                                   input logic [3:0]     n);
        logic [2*Y_W-1:0] w_dbl;
        w_dbl = {d, d} >> (LANE_W * int'(n));
        return w_dbl[Y_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/top_with_mem_y_mem.sv
`default_nettype none
// ============================================================================
// Module      : y_mem
// Description : Y-matrix row store with two asynchronous read ports. Contents
//               are loaded externally and are not touched by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module y_mem
    import top_with_mem_pkg::*;
(
    input  logic [7:0]     addr1,
    output logic [Y_W-1:0] data1,
    input  logic [7:0]     addr2,
    output logic [Y_W-1:0] data2
);

    reg [255:0] Register [0:255];

    assign data1 = Register[addr1];
    assign data2 = Register[addr2];

endmodule
`default_nettype wire

// File: rtl/top_with_mem.sv
`default_nettype none
// ============================================================================
// Module      : top_with_mem
// Description : Memory wrapper: image memory write path plus a registered,
//               lane-aligned pair of adjacent Y-matrix rows.
// Revision    : 1.0 - initial release
// ============================================================================
module top_with_mem
    import top_with_mem_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           iMem_WEPin,
    input  logic [7:0]     iMem_WEAddress,
    input  logic [I_W-1:0] idataWrite,
    input  logic [15:0]    topmem_chgTxt_row,
    input  logic [15:0]    topmem_chgTxt_col,
    output logic [Y_W-1:0] topmem_yMatOut1,
    output logic [Y_W-1:0] topmem_yMatOut2
);

    logic [I_W-1:0] iMem [0:I_DEPTH-1];

    logic [7:0]     w_addr_a;
    logic [7:0]     w_addr_b;
    logic [3:0]     w_lane;
    logic [Y_W-1:0] w_row_a;
    logic [Y_W-1:0] w_row_b;
    logic [Y_W-1:0] r_ymat1;
    logic [Y_W-1:0] r_ymat2;
    logic           w_unused_bits;

    assign w_addr_a = topmem_chgTxt_row[7:0];
    assign w_addr_b = w_addr_a + 8'd1;   // row 255 pairs with row 0
    assign w_lane   = topmem_chgTxt_col[3:0];

    // Image memory has no read port here and is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (!reset && iMem_WEPin) begin
            iMem[iMem_WEAddress] <= idataWrite;
        end
    end

    y_mem Y_mem (
        .addr1 (w_addr_a),
        .data1 (w_row_a),
        .addr2 (w_addr_b),
        .data2 (w_row_b)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ymat1 <= '0;
            r_ymat2 <= '0;
        end else begin
            r_ymat1 <= lane_rotate(w_row_a, w_lane);
            r_ymat2 <= lane_rotate(w_row_b, w_lane);
        end
    end

    assign topmem_yMatOut1 = r_ymat1;
    assign topmem_yMatOut2 = r_ymat2;

    assign w_unused_bits = ^{topmem_chgTxt_row[15:8], topmem_chgTxt_col[15:4],
                             iMem[iMem_WEAddress]};

endmodule
`default_nettype wire

// File: tb/tb_top_with_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_with_mem
// Description : Directed self-checking bench for top_with_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_with_mem;

    logic         clock;
    logic         reset;
    logic         iMem_WEPin;
    logic [7:0]   iMem_WEAddress;
    logic [239:0] idataWrite;
    logic [15:0]  topmem_chgTxt_row;
    logic [15:0]  topmem_chgTxt_col;
    logic [255:0] topmem_yMatOut1;
    logic [255:0] topmem_yMatOut2;

    int n_cmp;
    int n_err;

    top_with_mem dut (
        .clock             (clock),
        .reset             (reset),
        .iMem_WEPin        (iMem_WEPin),
        .iMem_WEAddress    (iMem_WEAddress),
        .idataWrite        (idataWrite),
        .topmem_chgTxt_row (topmem_chgTxt_row),
        .topmem_chgTxt_col (topmem_chgTxt_col),
        .topmem_yMatOut1   (topmem_yMatOut1),
        .topmem_yMatOut2   (topmem_yMatOut2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] row_val(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {16{b, 8'hA5}};
    endfunction

    // Lane j of the result is lane (j + c) mod 16 of the source.
    function automatic logic [255:0] rot_model(input logic [255:0] d, input int c);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[16*j +: 16] = d[16*((j + c) % 16) +: 16];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [239:0] d1, d2, d3, d4;
    logic [255:0] r3;

    initial begin
        n_cmp = 0;
        n_err = 0;
        d1 = {15{16'h1234}};
        d2 = {15{16'h0F0F}};
        d3 = {15{16'hBEEF}};
        d4 = {15{16'hDEAD}};
        reset             = 1'b1;
        iMem_WEPin        = 1'b0;
        iMem_WEAddress    = 8'h00;
        idataWrite        = '0;
        topmem_chgTxt_row = 16'h0000;
        topmem_chgTxt_col = 16'h0000;
        for (int n = 0; n < 256; n++) begin
            dut.Y_mem.Register[n] = row_val(n);
        end

        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_out1", topmem_yMatOut1, '0);
            check("rst_out2", topmem_yMatOut2, '0);
        end

        reset = 1'b0;
        step();
        check("first_out1", topmem_yMatOut1, row_val(0));
        check("first_out2", topmem_yMatOut2, row_val(1));

        topmem_chgTxt_row = 16'h01FF;
        step();
        check("wrap_out1", topmem_yMatOut1, row_val(255));
        check("wrap_out2", topmem_yMatOut2, row_val(0));

        topmem_chgTxt_row = 16'h0003;
        topmem_chgTxt_col = 16'h0011;
        step();
        r3 = row_val(3);
        check("rot1_out1", topmem_yMatOut1, {r3[15:0], r3[255:16]});
        check("rot1_out2", topmem_yMatOut2, rot_model(row_val(4), 1));

        topmem_chgTxt_col = 16'h0000;
        step();
        check("rot0_out1", topmem_yMatOut1, row_val(3));
        check("rot0_out2", topmem_yMatOut2, row_val(4));

        topmem_chgTxt_row = 16'hAB07;
        topmem_chgTxt_col = 16'hFFFF;
        step();
        check("rot15_out1", topmem_yMatOut1, rot_model(row_val(7), 15));
        check("rot15_out2", topmem_yMatOut2, rot_model(row_val(8), 15));

        topmem_chgTxt_row = 16'h0080;
        topmem_chgTxt_col = 16'h0008;
        step();
        check("rot8_out1", topmem_yMatOut1, rot_model(row_val(128), 8));
        check("rot8_out2", topmem_yMatOut2, rot_model(row_val(129), 8));

        iMem_WEPin     = 1'b1;
        iMem_WEAddress = 8'h10;
        idataWrite     = d1;
        step();
        iMem_WEPin = 1'b0;
        check("imem_wr", {16'h0, dut.iMem[16]}, {16'h0, d1});

        iMem_WEPin     = 1'b1;
        iMem_WEAddress = 8'h11;
        idataWrite     = d2;
        step();
        idataWrite     = d3;
        step();
        iMem_WEPin = 1'b0;
        check("imem_last", {16'h0, dut.iMem[17]}, {16'h0, d3});

        topmem_chgTxt_row = 16'h0005;
        topmem_chgTxt_col = 16'h0000;
        step();
        check("pre_rst_out1", topmem_yMatOut1, row_val(5));

        reset          = 1'b1;
        iMem_WEPin     = 1'b1;
        iMem_WEAddress = 8'h10;
        idataWrite     = d4;
        step();
        check("mid_rst_out1", topmem_yMatOut1, '0);
        check("mid_rst_out2", topmem_yMatOut2, '0);
        reset      = 1'b0;
        iMem_WEPin = 1'b0;
        check("imem_rst_wr", {16'h0, dut.iMem[16]}, {16'h0, d1});
        step();
        check("post_rst_out1", topmem_yMatOut1, row_val(5));
        check("post_rst_out2", topmem_yMatOut2, row_val(6));
        check("ymem_kept", dut.Y_mem.Register[5], row_val(5));
        check("imem_kept", {16'h0, dut.iMem[17]}, {16'h0, d3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
